// File: rtl/cpu_step_controller_pkg.sv
// Shared types and constants for the CPU single-step / run controller.
package cpu_step_controller_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_STEP  = 2'd1,
      ST_BURST = 2'd2,
      ST_RUN   = 2'd3
   } state_e;

   function automatic logic bp_match(input logic en, input logic [31:0] pc, input logic [31:0] bp);
      return en & (pc == bp);
   endfunction

endpackage

// File: rtl/cpu_step_controller_button_debouncer.sv
// Synchronizer, run-length debouncer and rising-edge press detector for one button.
module button_debouncer
   import cpu_step_controller_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic [1:0]    sync_q, sync_d;
   logic [1:0]    fill_q, fill_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          armed_q, armed_d;
   logic          press_q, press_d;

   // Sampling register bank for synchronizer, debounce state and press pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b00;
         fill_q  <= 2'b00;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         armed_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         fill_q  <= fill_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         armed_q <= armed_d;
         press_q <= press_d;
      end
   end

   // Samples count only once the synchronizer holds real data; a press needs a
   // confirmed low level first, so a button held through reset stays silent.
   always_comb begin
      sync_d  = {sync_q[0], btn_raw};
      fill_d  = {fill_q[0], 1'b1};
      last_d  = last_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      armed_d = armed_q;
      if (fill_q[1]) begin
         if (sync_q[1] != last_q) begin
            last_d = sync_q[1];
            cnt_d  = CW'(1);
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
         end else begin
            cnt_d = cnt_q;
         end
         if (cnt_d == CNT_MAX) begin
            level_d = last_d;
            armed_d = armed_q | ~last_d;
         end else begin
            level_d = level_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
      press_d = armed_q & ~level_q & level_d;
   end

   assign press = press_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Debounced step/run front panel driving a CPU clock enable, with burst mode and a
// single address breakpoint.
module cpu_step_controller
   import cpu_step_controller_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_step,
   input  logic        btn_run,
   input  logic        mode_burst,
   input  logic [7:0]  sw_burst,
   input  logic [31:0] pc,
   input  logic [31:0] bp_addr,
   input  logic        bp_en,
   output logic        clk_en,
   output logic        halted,
   output logic        bp_hit,
   output logic [31:0] cycle_count
);

   state_e      state_q, state_d;
   logic [7:0]  rem_q, rem_d;
   logic        first_q, first_d;
   logic        bp_hit_q, bp_hit_d;
   logic [31:0] cnt_q, cnt_d;
   logic        step_press_s, run_press_s, bp_stop_s, clk_en_s;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
      .clk(clk), .rst(rst), .btn_raw(btn_step), .press(step_press_s)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
      .clk(clk), .rst(rst), .btn_raw(btn_run), .press(run_press_s)
   );

   // The first cycle after leaving IDLE never stops on the breakpoint, so a CPU
   // parked on the breakpoint address can be resumed.
   assign bp_stop_s = ~first_q & bp_match(bp_en, pc, bp_addr);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rem_q    <= 8'd0;
         first_q  <= 1'b0;
         bp_hit_q <= 1'b0;
         cnt_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         first_q  <= first_d;
         bp_hit_q <= bp_hit_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      first_d  = 1'b0;
      bp_hit_d = bp_hit_q;
      if (clk_en_s) begin
         cnt_d = cnt_q + 32'd1;
      end else begin
         cnt_d = cnt_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (run_press_s) begin
               state_d  = ST_RUN;
               first_d  = 1'b1;
               bp_hit_d = 1'b0;
            end else if (step_press_s) begin
               bp_hit_d = 1'b0;
               if (mode_burst && (sw_burst >= 8'd2)) begin
                  state_d = ST_BURST;
                  rem_d   = sw_burst;
                  first_d = 1'b1;
               end else begin
                  state_d = ST_STEP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STEP: begin
            state_d = ST_IDLE;
         end
         ST_BURST: begin
            if (run_press_s) begin
               state_d = ST_IDLE;
               rem_d   = 8'd0;
            end else if (bp_stop_s) begin
               state_d  = ST_IDLE;
               rem_d    = 8'd0;
               bp_hit_d = 1'b1;
            end else if (rem_q == 8'd1) begin
               state_d = ST_IDLE;
               rem_d   = 8'd0;
            end else begin
               rem_d = rem_q - 8'd1;
            end
         end
         ST_RUN: begin
            if (run_press_s) begin
               state_d = ST_IDLE;
            end else if (bp_stop_s) begin
               state_d  = ST_IDLE;
               bp_hit_d = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rem_d   = 8'd0;
         end
      endcase
   end

   // Output logic.
   always_comb begin
      case (state_q)
         ST_IDLE:          clk_en_s = 1'b0;
         ST_STEP:          clk_en_s = 1'b1;
         ST_BURST, ST_RUN: clk_en_s = ~run_press_s & ~bp_stop_s;
         default:          clk_en_s = 1'b0;
      endcase
   end

   assign clk_en      = clk_en_s;
   assign halted      = (state_q == ST_IDLE);
   assign bp_hit      = bp_hit_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: behavioural model compared every cycle plus literal checkpoints.
module tb_cpu_step_controller;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_step, btn_run, mode_burst, bp_en;
   logic [7:0]  sw_burst;
   logic [31:0] pc, bp_addr, pc_base;
   logic        clk_en, halted, bp_hit;
   logic [31:0] cycle_count;

   int unsigned en_cnt = 0;
   int          n_pass = 0;
   int          n_total = 0;

   assign pc = pc_base + (en_cnt * 32'd4);

   always #5 clk = ~clk;

   cpu_step_controller #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .btn_step(btn_step), .btn_run(btn_run),
      .mode_burst(mode_burst), .sw_burst(sw_burst), .pc(pc), .bp_addr(bp_addr),
      .bp_en(bp_en), .clk_en(clk_en), .halted(halted), .bp_hit(bp_hit),
      .cycle_count(cycle_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model: m_left = 0 idle, -1 run forever, k>0 enables still owed.
   int          m_left;
   bit          m_stoppable, m_first, m_bp_hit;
   logic [31:0] m_count;
   bit          q_step[$];
   bit          q_run[$];
   bit          m_pend[2];
   bit          m_acc[2];
   bit          m_armed[2];
   bit          m_rval[2];
   int          m_rlen[2];

   function automatic bit exp_en();
      if (m_left == 0) return 1'b0;
      if (!m_stoppable) return 1'b1;
      if (m_pend[1]) return 1'b0;
      if (!m_first && bp_en && (pc == bp_addr)) return 1'b0;
      return 1'b1;
   endfunction

   initial begin : model
      bit en;
      bit samp[2];
      bit sv[2];
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_left = 0; m_stoppable = 0; m_first = 0; m_bp_hit = 0; m_count = 32'd0;
            q_step.delete(); q_run.delete();
            for (int b = 0; b < 2; b++) begin
               m_pend[b] = 0; m_acc[b] = 0; m_armed[b] = 0; m_rval[b] = 0; m_rlen[b] = 0;
            end
         end else begin
            en = exp_en();
            if (en) begin
               m_count = m_count + 32'd1;
               en_cnt <= en_cnt + 1;
            end
            if (m_left == 0) begin
               if (m_pend[1]) begin
                  m_left = -1; m_stoppable = 1; m_first = 1; m_bp_hit = 0;
               end else if (m_pend[0]) begin
                  m_bp_hit = 0;
                  if (mode_burst && (int'(sw_burst) >= 2)) begin
                     m_left = int'(sw_burst); m_stoppable = 1; m_first = 1;
                  end else begin
                     m_left = 1; m_stoppable = 0; m_first = 0;
                  end
               end
            end else if (!en) begin
               if (!m_pend[1]) m_bp_hit = 1;
               m_left = 0;
            end else begin
               if (m_left > 0) m_left--;
               m_first = 0;
            end
            // Button front end: two-edge sample delay, then run-length acceptance.
            q_step.push_back(btn_step);
            q_run.push_back(btn_run);
            sv[0] = 0; sv[1] = 0; samp[0] = 0; samp[1] = 0;
            if (q_step.size() > 2) begin samp[0] = q_step.pop_front(); sv[0] = 1; end
            if (q_run.size() > 2) begin samp[1] = q_run.pop_front(); sv[1] = 1; end
            for (int b = 0; b < 2; b++) begin
               m_pend[b] = 0;
               if (sv[b]) begin
                  if (samp[b] == m_rval[b]) begin
                     if (m_rlen[b] < D) m_rlen[b]++;
                  end else begin
                     m_rval[b] = samp[b];
                     m_rlen[b] = 1;
                  end
                  if (m_rlen[b] >= D) begin
                     if (m_rval[b] && !m_acc[b] && m_armed[b]) m_pend[b] = 1;
                     if (!m_rval[b]) m_armed[b] = 1;
                     m_acc[b] = m_rval[b];
                  end
               end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("clk_en",      {31'd0, clk_en}, {31'd0, exp_en()});
            chk("halted",      {31'd0, halted}, {31'd0, (m_left == 0)});
            chk("bp_hit",      {31'd0, bp_hit}, {31'd0, m_bp_hit});
            chk("cycle_count", cycle_count,     m_count);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_step(input int hold);
      btn_step = 1'b1; cyc(hold); btn_step = 1'b0; cyc(12);
   endtask

   task automatic press_run(input int hold);
      btn_run = 1'b1; cyc(hold); btn_run = 1'b0; cyc(12);
   endtask

   initial begin : stim
      rst = 1'b1; btn_step = 1'b0; btn_run = 1'b0; mode_burst = 1'b0; sw_burst = 8'd0;
      bp_addr = 32'd0; bp_en = 1'b0; pc_base = 32'd0;
      cyc(3);
      chk("rst_clk_en", {31'd0, clk_en}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd1);
      chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
      chk("rst_count",  cycle_count,     32'd0);
      rst = 1'b0;
      cyc(10);

      press_step(8);
      chk("step_count",  cycle_count,     32'd1);
      chk("step_halted", {31'd0, halted}, 32'd1);

      mode_burst = 1'b1; sw_burst = 8'd5;
      press_step(8);
      chk("burst_count",  cycle_count,     32'd6);
      chk("burst_halted", {31'd0, halted}, 32'd1);
      mode_burst = 1'b0;

      pc_base = 32'h0040_0000 - (en_cnt * 32'd4);
      bp_addr = 32'h0040_0010; bp_en = 1'b1;
      press_run(8);
      chk("bp_count",  cycle_count,     32'd10);
      chk("bp_hit",    {31'd0, bp_hit}, 32'd1);
      chk("bp_pc",     pc,              32'h0040_0010);
      chk("bp_halted", {31'd0, halted}, 32'd1);
      press_step(8);
      chk("bp_step_count", cycle_count,     32'd11);
      chk("bp_step_clear", {31'd0, bp_hit}, 32'd0);
      chk("bp_step_pc",    pc,              32'h0040_0014);
      bp_en = 1'b0;

      for (int i = 0; i < 5; i++) begin
         btn_step = ((i % 2) == 0); cyc(2);
      end
      btn_step = 1'b1; cyc(10); btn_step = 1'b0; cyc(12);
      chk("bounce_count", cycle_count, 32'd12);

      btn_run = 1'b1; btn_step = 1'b1; cyc(8);
      btn_run = 1'b0; btn_step = 1'b0; cyc(6);
      chk("both_running", {31'd0, halted}, 32'd0);
      press_step(8);
      chk("step_ignored", {31'd0, halted}, 32'd0);
      press_run(8);
      chk("run_stopped", {31'd0, halted}, 32'd1);
      chk("run_no_bp",   {31'd0, bp_hit}, 32'd0);

      btn_run = 1'b1; cyc(8); btn_run = 1'b0; cyc(6);
      chk("pre_rst_running", {31'd0, halted}, 32'd0);
      @(negedge clk); #2;
      btn_run = 1'b1; rst = 1'b1;
      #1;
      chk("rst_mid_clk_en", {31'd0, clk_en}, 32'd0);
      chk("rst_mid_count",  cycle_count,     32'd0);
      chk("rst_mid_halted", {31'd0, halted}, 32'd1);
      cyc(3);
      rst = 1'b0;
      cyc(20);
      chk("held_no_press", {31'd0, halted}, 32'd1);
      chk("held_count",    cycle_count,     32'd0);
      btn_run = 1'b0; cyc(12);
      btn_run = 1'b1; cyc(8); btn_run = 1'b0; cyc(4);
      chk("repress_running", {31'd0, halted}, 32'd0);
      press_run(8);
      chk("repress_stopped", {31'd0, halted}, 32'd1);

      cyc(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
